uba_intr: RTL and testbench
===========================

// Module: uba_intr
// PURPOSE
//   UBA interrupt controller, downstream of the UBA status register (UBASR).
//   - Maps device BR7..BR4 requests onto KS10 PI levels, using the PIH/PIL fields of regUBASR.
//   - Services the CPU interrupt-acknowledge cycle: arbitrates devices, handshakes the winner, returns its vector.
// PARAMETERS
//   TMO_CYCLES  64  clocks to wait for a device vector before abandoning the acknowledge (UBA_IACK_TMO_EN only)
// PORTS
//   clk          in   1       clock
//   rst          in   1       synchronous reset, active high
//   regUBASR     in   [0:35]  status reg; uses PIH[30:32], PIL[33:35], INI[29]
//   devINTR      in   [7:4]x4 per-device bus request lines BR7..BR4, devices [1:4]
//   busIACK      in   1       one-clock pulse: CPU acknowledges PI level busIPI
//   busIPI       in   [1:3]   PI level being acknowledged (1..7)
//   devVECT      in   [18:35]x4  device vector, valid while that device's devVACK=1
//   devVACK      in   1x4     device vector-valid response
//   busINTR      out  [1:7]   PI request to CPU
//   devIACK      out  1x4     grant to the selected device (one-hot)
//   busVACK      out  1       one-clock pulse: busVECT valid
//   busVECT      out  [0:35]  vector to CPU, {18'b0, devVECT}
//   iackTMO      out  1       one-clock pulse: acknowledge timed out; UBASR sets TMO from it
// BEHAVIOUR
//   - Reset: all outputs 0; FSM in IDLE; latched winner cleared.
//   - INI: regUBASR[29]=1 acts as a synchronous reset on the same clock.
//   - HI request = OR of devINTR[*][7:6]; LO request = OR of devINTR[*][5:4].
//   - busINTR[n] is registered, one clock after its inputs change:
//     (HI & PIH==n) | (LO & PIL==n). PIH/PIL==0 disables that level.
//   - FSM states: IDLE, ARB, WAIT, DONE.
//   - IDLE:
//     - on busIACK, latch busIPI, then go to ARB.
//     - busIACK while not in IDLE is ignored; no queueing.
//   - ARB: pick class, then device.
//     - Class: HI if PIH==ipi and HI pending; else LO if PIL==ipi and LO pending; else none.
//     - If PIH==PIL==ipi, HI wins.
//     - Device within class: higher BR first (7>6, 5>4), then lowest device number.
//     - No winner: return to IDLE silently. Another adapter may own the level; no ack, no error.
//     - Winner: register the one-hot grant, then go to WAIT.
//   - WAIT: devIACK[winner]=1 every WAIT cycle.
//     - On devVACK[winner]=1: capture devVECT[winner], go to DONE.
//     - devVACK from a non-selected device is ignored.
//   - DONE: busVACK=1 and busVECT valid for exactly one clock; devIACK drops; go to IDLE.
//   - Acknowledge latency: busIACK to busVACK is at least 3 clocks (device answering on its first WAIT cycle).
//   - busVECT holds its value until the next capture.
//   - A device that drops its request during WAIT is not dropped; the grant stands.
// CONFIGURATION
//   - UBA_IACK_TMO_EN defined:
//     - WAIT loads a down-counter with TMO_CYCLES-1.
//     - If the counter reaches 0 with no devVACK: pulse iackTMO, no busVACK, drop devIACK, go to IDLE.
//     - devVACK on the terminal count cycle wins over the timeout.
//   - UBA_IACK_TMO_EN undefined: no counter; WAIT waits indefinitely; iackTMO tied to 0.
// STRUCTURE
//   - Shared package uba_pkg:
//     - state enum intrState_t {IDLE, ARB, WAIT, DONE};
//     - UBASR field bit positions PIH/PIL/INI;
//     - default TMO constant.
//   - Sub-module uba_intr_arb: combinational priority encoder.
//     - Inputs: devINTR, class select. Output: one-hot device plus valid.
//   - FSM, PI mapping and timeout counter live in uba_intr.
// TESTING
//   1. PIH=3, PIL=5; dev2 raises BR6 -> busINTR=7'b0010000 (level 3) one clock later; dev2 BR4 additionally -> level 5 also set.
//   2. PIH=3, dev1 BR7 + dev3 BR6 pending; busIACK ipi=3 -> devIACK[1]=1; dev1 VACK with 18'o000340 -> busVACK pulse, busVECT=36'o000000000340.
//   3. PIH=PIL=2, dev4 BR7 + dev1 BR5; busIACK ipi=2 -> dev4 granted (HI beats LO).
//   4. busIACK ipi=6, no mapped class -> FSM back to IDLE; no devIACK, busVACK or iackTMO.
//   5. UBA_IACK_TMO_EN, TMO_CYCLES=8, granted device never answers -> iackTMO pulse 8 clocks after WAIT entry; devIACK low; no busVACK.
//   6. rst, then INI write, each mid-WAIT -> next clock: devIACK=0, busINTR=0, FSM IDLE; a new busIACK then completes normally.

Source files
------------

// File: rtl/uba_pkg.sv
// Shared definitions for the UBA interrupt controller: FSM states, UBASR field
// positions and the default acknowledge timeout.
package uba_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    WAIT,
    DONE
  } intrState_t;

  localparam int unsigned NUM_DEV       = 4;
  localparam int unsigned UBASR_INI     = 29;
  localparam int unsigned UBASR_PIH_MSB = 30;
  localparam int unsigned UBASR_PIH_LSB = 32;
  localparam int unsigned UBASR_PIL_MSB = 33;
  localparam int unsigned UBASR_PIL_LSB = 35;
  localparam int unsigned TMO_DEFAULT   = 64;

  // A PI assignment of 0 means the class is not mapped to any level.
  function automatic logic pi_match(input logic [2:0] lvl, input logic [2:0] ipi);
    return (lvl != 3'd0) && (lvl == ipi);
  endfunction

endpackage

// File: rtl/uba_intr_arb.sv
// Device priority encoder: within the selected class the higher BR line wins,
// then the lowest-numbered device.
module uba_intr_arb
  import uba_pkg::*;
(
  input  logic [7:4]       devINTR [1:NUM_DEV],
  input  logic             sel_hi,
  output logic [1:NUM_DEV] grant,
  output logic             valid
);

  logic [1:NUM_DEV] upper;
  logic [1:NUM_DEV] lower;

  always_comb begin
    upper = '0;
    lower = '0;
    grant = '0;
    valid = 1'b0;
    for (int unsigned d = 1; d <= NUM_DEV; d++) begin
      upper[d] = sel_hi ? devINTR[d][7] : devINTR[d][5];
      lower[d] = sel_hi ? devINTR[d][6] : devINTR[d][4];
    end
    for (int unsigned d = 1; d <= NUM_DEV; d++) begin
      if (!valid && upper[d]) begin
        grant[d] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int unsigned d = 1; d <= NUM_DEV; d++) begin
      if (!valid && lower[d]) begin
        grant[d] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uba_intr.sv
// UBA interrupt controller: BR7..BR4 to PI level mapping and the acknowledge
// handshake. Optional acknowledge timeout enabled by UBA_IACK_TMO_EN.
module uba_intr
  import uba_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:35]      regUBASR,
  input  logic [7:4]       devINTR [1:NUM_DEV],
  input  logic             busIACK,
  input  logic [1:3]       busIPI,
  input  logic [18:35]     devVECT [1:NUM_DEV],
  input  logic [1:NUM_DEV] devVACK,
  output logic [1:7]       busINTR,
  output logic [1:NUM_DEV] devIACK,
  output logic             busVACK,
  output logic [0:35]      busVECT,
  output logic             iackTMO
);

  logic [2:0]  pih;
  logic [2:0]  pil;
  logic        clr;
  logic        unused_ubasr;

  assign pih          = regUBASR[UBASR_PIH_MSB:UBASR_PIH_LSB];
  assign pil          = regUBASR[UBASR_PIL_MSB:UBASR_PIL_LSB];
  assign clr          = rst | regUBASR[UBASR_INI];
  assign unused_ubasr = ^regUBASR[0:UBASR_INI-1];

  intrState_t       state_q, state_d;
  logic [2:0]       ipi_q, ipi_d;
  logic [1:NUM_DEV] grant_q, grant_d;
  logic [1:7]       busintr_q, busintr_d;
  logic             busvack_q, busvack_d;
  logic [0:35]      busvect_q, busvect_d;
  logic             tmo_q, tmo_d;

`ifdef UBA_IACK_TMO_EN
  localparam int unsigned CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic             hi_req;
  logic             lo_req;
  logic             sel_hi;
  logic             sel_lo;
  logic [1:NUM_DEV] arb_grant;
  logic             arb_valid;
  logic             vack_win;
  logic [18:35]     vect_mux;

  always_comb begin
    hi_req = 1'b0;
    lo_req = 1'b0;
    for (int unsigned d = 1; d <= NUM_DEV; d++) begin
      hi_req = hi_req | (|devINTR[d][7:6]);
      lo_req = lo_req | (|devINTR[d][5:4]);
    end
  end

  always_comb begin
    busintr_d = '0;
    for (int unsigned n = 1; n <= 7; n++) begin
      busintr_d[n] = (hi_req && (pih == 3'(n))) || (lo_req && (pil == 3'(n)));
    end
  end

  // HI takes precedence when both classes map to the acknowledged level.
  assign sel_hi = pi_match(pih, ipi_q) && hi_req;
  assign sel_lo = pi_match(pil, ipi_q) && lo_req;

  uba_intr_arb u_arb (
    .devINTR (devINTR),
    .sel_hi  (sel_hi),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  always_comb begin
    vect_mux = '0;
    for (int unsigned d = 1; d <= NUM_DEV; d++) begin
      if (grant_q[d]) vect_mux = vect_mux | devVECT[d];
    end
  end

  assign vack_win = |(devVACK & grant_q);

  always_comb begin
    state_d   = state_q;
    ipi_d     = ipi_q;
    grant_d   = grant_q;
    busvack_d = 1'b0;
    busvect_d = busvect_q;
    tmo_d     = 1'b0;
`ifdef UBA_IACK_TMO_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (busIACK) begin
          ipi_d   = busIPI;
          state_d = ARB;
        end
      end
      ARB: begin
        if ((sel_hi || sel_lo) && arb_valid) begin
          grant_d = arb_grant;
          state_d = WAIT;
`ifdef UBA_IACK_TMO_EN
          cnt_d   = CNT_W'(TMO_CYCLES - 1);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (vack_win) begin
          busvect_d = {18'b0, vect_mux};
          busvack_d = 1'b1;
          grant_d   = '0;
          state_d   = DONE;
        end
`ifdef UBA_IACK_TMO_EN
        else if (cnt_q == '0) begin
          tmo_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      ipi_q     <= '0;
      grant_q   <= '0;
      busintr_q <= '0;
      busvack_q <= 1'b0;
      busvect_q <= '0;
      tmo_q     <= 1'b0;
`ifdef UBA_IACK_TMO_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ipi_q     <= ipi_d;
      grant_q   <= grant_d;
      busintr_q <= busintr_d;
      busvack_q <= busvack_d;
      busvect_q <= busvect_d;
      tmo_q     <= tmo_d;
`ifdef UBA_IACK_TMO_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busINTR = busintr_q;
  assign devIACK = grant_q;
  assign busVACK = busvack_q;
  assign busVECT = busvect_q;
  assign iackTMO = tmo_q;

endmodule

// File: tb/tb_uba_intr.sv
// Scoreboard bench for uba_intr: directed cases plus randomized acknowledges
// checked against a rule-level reference model.
module tb_uba_intr;
  import uba_pkg::*;

`ifdef UBA_IACK_TMO_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 64;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [0:35]   regUBASR;
  logic [7:4]    devINTR [1:4];
  logic          busIACK;
  logic [1:3]    busIPI;
  logic [18:35]  devVECT [1:4];
  logic [1:4]    devVACK;
  logic [1:7]    busINTR;
  logic [1:4]    devIACK;
  logic          busVACK;
  logic [0:35]   busVECT;
  logic          iackTMO;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  logic [0:35]   exp_q [$];
  bit            tmo_allowed = 1'b0;

  uba_intr #(.TMO_CYCLES(TB_TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .regUBASR (regUBASR),
    .devINTR  (devINTR),
    .busIACK  (busIACK),
    .busIPI   (busIPI),
    .devVECT  (devVECT),
    .devVACK  (devVACK),
    .busINTR  (busINTR),
    .devIACK  (devIACK),
    .busVACK  (busVACK),
    .busVECT  (busVECT),
    .iackTMO  (iackTMO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_br(input int br);
    for (int d = 1; d <= 4; d++) if (devINTR[d][br]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:7] model_intr();
    logic [1:7] r = '0;
    bit h = any_br(7) || any_br(6);
    bit l = any_br(5) || any_br(4);
    int ph = int'(regUBASR[30:32]);
    int pl = int'(regUBASR[33:35]);
    for (int n = 1; n <= 7; n++) r[n] = (h && ph == n) || (l && pl == n);
    return r;
  endfunction

  function automatic int ref_winner(input int ipi);
    int ph = int'(regUBASR[30:32]);
    int pl = int'(regUBASR[33:35]);
    int top;
    if (ph != 0 && ph == ipi && (any_br(7) || any_br(6))) top = 7;
    else if (pl != 0 && pl == ipi && (any_br(5) || any_br(4))) top = 5;
    else return 0;
    for (int br = top; br >= top - 1; br--)
      for (int d = 1; d <= 4; d++)
        if (devINTR[d][br]) return d;
    return 0;
  endfunction

  function automatic logic [1:4] oh(input int d);
    logic [1:4] r = '0;
    if (d >= 1 && d <= 4) r[d] = 1'b1;
    return r;
  endfunction

  // busINTR follows the inputs seen at the previous rising edge.
  initial begin
    logic [1:7] exp_i;
    forever begin
      @(posedge clk);
      exp_i = (rst || regUBASR[29]) ? '0 : model_intr();
      @(negedge clk);
      check("busINTR", busINTR, exp_i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busVACK === 1'b1) begin
        if (exp_q.size() == 0) check("busVACK_unexpected", busVACK, 0);
        else check("busVECT", busVECT, exp_q.pop_front());
      end
      if (iackTMO !== 1'b0 && !tmo_allowed) check("iackTMO_spurious", iackTMO, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic set_map(input int ph, input int pl);
    regUBASR        = '0;
    regUBASR[30:32] = ph[2:0];
    regUBASR[33:35] = pl[2:0];
  endtask

  task automatic clear_reqs();
    for (int d = 1; d <= 4; d++) devINTR[d] = '0;
  endtask

  // Returns at the falling edge of the first WAIT cycle.
  task automatic start_grant(input int ipi, input int w);
    busIACK = 1'b1;
    busIPI  = ipi[2:0];
    @(negedge clk);
    busIACK = 1'b0;
    @(negedge clk);
    check("devIACK_grant", devIACK, oh(w));
    if (w == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("devIACK_none", devIACK, '0);
      end
    end
  endtask

  task automatic finish_grant(input int w, input logic [18:35] vec, input int delay, input bit decoys);
    int o;
    if (decoys && $urandom_range(0, 1) == 1) begin
      o = (w % 4) + 1;
      devVACK[o] = 1'b1;
      devVECT[o] = 18'($urandom);
      @(negedge clk);
      devVACK = '0;
      check("devIACK_decoy_vack", devIACK, oh(w));
    end
    for (int i = 0; i < delay; i++) begin
      if (decoys && $urandom_range(0, 3) == 0) begin
        busIACK = 1'b1;
        busIPI  = 3'($urandom_range(1, 7));
      end
      if (decoys && $urandom_range(0, 3) == 0) devINTR[w] = '0;
      @(negedge clk);
      busIACK = 1'b0;
      check("devIACK_hold", devIACK, oh(w));
    end
    exp_q.push_back({18'b0, vec});
    devVACK[w] = 1'b1;
    devVECT[w] = vec;
    @(negedge clk);
    devVACK = '0;
    devVECT[w] = 18'($urandom);
    check("devIACK_done", devIACK, '0);
    @(negedge clk);
    check("busVACK_pending", exp_q.size(), 0);
    exp_q.delete();
    check("devIACK_idle", devIACK, '0);
    check("busVECT_hold", busVECT, {18'b0, vec});
  endtask

  initial begin
    int w, ipi, ph, pl;
    rst      = 1'b1;
    regUBASR = '0;
    busIACK  = 1'b0;
    busIPI   = '0;
    devVACK  = '0;
    for (int d = 1; d <= 4; d++) begin
      devINTR[d] = '0;
      devVECT[d] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_devIACK", devIACK, '0);
    check("rst_busVACK", busVACK, 0);
    check("rst_busVECT", busVECT, '0);
    check("rst_iackTMO", iackTMO, 0);
    rst = 1'b0;
    @(negedge clk);

    set_map(3, 5);
    devINTR[2] = 4'b0100;
    @(negedge clk);
    check("t1_level3", busINTR, 7'b0010000);
    devINTR[2] = 4'b0101;
    @(negedge clk);
    check("t1_level3_5", busINTR, 7'b0010100);

    clear_reqs();
    set_map(3, 0);
    devINTR[1] = 4'b1000;
    devINTR[3] = 4'b0100;
    @(negedge clk);
    start_grant(3, 1);
    finish_grant(1, 18'o000340, 0, 1'b0);

    clear_reqs();
    set_map(2, 2);
    devINTR[4] = 4'b1000;
    devINTR[1] = 4'b0010;
    @(negedge clk);
    start_grant(2, 4);
    finish_grant(4, 18'o123456, 1, 1'b0);

    start_grant(6, 0);

`ifdef UBA_IACK_TMO_EN
    clear_reqs();
    set_map(3, 0);
    devINTR[1] = 4'b1000;
    @(negedge clk);
    start_grant(3, 1);
    tmo_allowed = 1'b1;
    w = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (iackTMO === 1'b1) begin
        w = i;
        break;
      end
    end
    check("t5_tmo_latency", w, 8);
    check("t5_devIACK", devIACK, '0);
    check("t5_busVACK", busVACK, 0);
    @(negedge clk);
    tmo_allowed = 1'b0;
    check("t5_tmo_pulse", iackTMO, 0);
    start_grant(3, 1);
    finish_grant(1, 18'o777001, 7, 1'b0);
`endif

    clear_reqs();
    set_map(3, 5);
    devINTR[2] = 4'b0100;
    @(negedge clk);
    start_grant(3, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_devIACK", devIACK, '0);
    check("t6_rst_busINTR", busINTR, '0);
    start_grant(3, 2);
    finish_grant(2, 18'o000104, 0, 1'b0);
    start_grant(3, 2);
    regUBASR[29] = 1'b1;
    @(negedge clk);
    regUBASR[29] = 1'b0;
    check("t6_ini_devIACK", devIACK, '0);
    check("t6_ini_busINTR", busINTR, '0);
    start_grant(3, 2);
    finish_grant(2, 18'o000210, 2, 1'b0);

    for (int it = 0; it < 150; it++) begin
      ph = $urandom_range(0, 7);
      pl = $urandom_range(0, 7);
      set_map(ph, pl);
      for (int d = 1; d <= 4; d++) devINTR[d] = 4'($urandom & $urandom);
      @(negedge clk);
      case ($urandom_range(0, 2))
        0:       ipi = (ph != 0) ? ph : $urandom_range(1, 7);
        1:       ipi = (pl != 0) ? pl : $urandom_range(1, 7);
        default: ipi = $urandom_range(1, 7);
      endcase
      w = ref_winner(ipi);
      start_grant(ipi, w);
      if (w != 0) finish_grant(w, 18'($urandom), $urandom_range(0, 3), 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
